apb_timer_mc_core: RTL and testbench

- Parametrised multi-channel timer core; successor to the single simple APB timer unit.
- Provides NUM_CH independent counters, each with a prescaler, compare/auto-reload, one-shot, continuous and event-count modes, per-channel interrupts, and a global freeze input.
- Accessed through a simple request/response register port; an APB bridge sits in front of it in the timer sub-system.
- Single clock domain: HCLK.

---
 rtl/apb_timer_mc_core.sv | 149 ++++++++++++++
 tb/tb_apb_timer_mc_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_mc_core.sv
// Multi-channel timer core: NUM_CH counters with prescaler, compare/auto-reload,
// one-shot / continuous / event-count modes, behind a registered request/response port.
module apb_timer_mc_core #(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 32,
  parameter  int PRESC_W = 8,
  localparam int ADDR_W  = $clog2(NUM_CH) + 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              stoptimer_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              reg_req_i,
  input  logic              reg_we_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [CNT_W-1:0]  reg_wdata_i,
  output logic [CNT_W-1:0]  reg_rdata_o,
  output logic              reg_rvalid_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_CONT    = 2'b01,
    MODE_EVENT   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [1:0] IDX_CFG = 2'd0;
  localparam logic [1:0] IDX_CMP = 2'd1;
  localparam logic [1:0] IDX_CNT = 2'd2;
  localparam logic [1:0] IDX_STS = 2'd3;

  logic [NUM_CH-1:0]  en, irq_en, flag, event_q;
  mode_e              mode  [NUM_CH];
  logic [PRESC_W-1:0] presc [NUM_CH];
  logic [PRESC_W-1:0] pc    [NUM_CH];
  logic [CNT_W-1:0]   cmp   [NUM_CH];
  logic [CNT_W-1:0]   cnt   [NUM_CH];

  logic [ADDR_W-1:0]  addr_ch;
  logic [1:0]         addr_idx;
  logic [NUM_CH-1:0]  wr_cfg, wr_cmp, wr_cnt, wr_sts, tick, match;
  logic [CNT_W-1:0]   rdata_nxt;

  assign addr_ch  = reg_addr_i >> 2;
  assign addr_idx = reg_addr_i[1:0];

  // Write decode and per-channel tick generation.
  always_comb begin
    wr_cfg = '0;
    wr_cmp = '0;
    wr_cnt = '0;
    wr_sts = '0;
    tick   = '0;
    match  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (reg_req_i && reg_we_i && (addr_ch == ADDR_W'(ch))) begin
        wr_cfg[ch] = (addr_idx == IDX_CFG);
        wr_cmp[ch] = (addr_idx == IDX_CMP);
        wr_cnt[ch] = (addr_idx == IDX_CNT);
        wr_sts[ch] = (addr_idx == IDX_STS);
      end
      if (en[ch] && !stoptimer_i) begin
        if (mode[ch] == MODE_EVENT) tick[ch] = event_i[ch] & ~event_q[ch];
        // >= keeps the channel ticking if presc is lowered below a running pc
        else tick[ch] = (pc[ch] >= presc[ch]);
      end
      match[ch] = tick[ch] && (cnt[ch] == cmp[ch]);
    end
  end

  // Read mux over pre-update register contents; unmapped channels read 0.
  always_comb begin
    rdata_nxt = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (addr_ch == ADDR_W'(ch)) begin
        case (addr_idx)
          IDX_CFG: begin
            rdata_nxt[0]             = en[ch];
            rdata_nxt[2:1]           = mode[ch];
            rdata_nxt[3]             = irq_en[ch];
            rdata_nxt[8 +: PRESC_W]  = presc[ch];
          end
          IDX_CMP: rdata_nxt = cmp[ch];
          IDX_CNT: rdata_nxt = cnt[ch];
          default: begin
            rdata_nxt[0] = flag[ch];
            rdata_nxt[1] = en[ch];
          end
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: the per-channel arrays are ordinary registers, not RAM, so they are
    // reset in a loop; every software-visible bit must read 0 after reset.
    if (!HRESETn) begin
      en           <= '0;
      irq_en       <= '0;
      flag         <= '0;
      event_q      <= '0;
      reg_rdata_o  <= '0;
      reg_rvalid_o <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode[ch]  <= MODE_ONESHOT;
        presc[ch] <= '0;
        pc[ch]    <= '0;
        cmp[ch]   <= '0;
        cnt[ch]   <= '0;
      end
    end else begin
      event_q      <= event_i;
      reg_rvalid_o <= reg_req_i & ~reg_we_i;
      if (reg_req_i && !reg_we_i) reg_rdata_o <= rdata_nxt;

      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (mode[ch] == MODE_EVENT) pc[ch] <= '0;
        else if (en[ch] && !stoptimer_i)
          pc[ch] <= tick[ch] ? '0 : pc[ch] + PRESC_W'(1);

        if (tick[ch]) cnt[ch] <= match[ch] ? '0 : cnt[ch] + CNT_W'(1);

        if (match[ch]) flag[ch] <= 1'b1;
        else if (wr_sts[ch] && reg_wdata_i[0]) flag[ch] <= 1'b0;

        if (match[ch] && mode[ch] == MODE_ONESHOT) en[ch] <= 1'b0;

        // NOTE: software writes come after the tick updates so that, with
        // non-blocking assignments, the last one scheduled wins the register.
        if (wr_cfg[ch]) begin
          en[ch]     <= reg_wdata_i[0];
          irq_en[ch] <= reg_wdata_i[3];
          presc[ch]  <= reg_wdata_i[8 +: PRESC_W];
          if (reg_wdata_i[2:1] != MODE_RSVD) mode[ch] <= mode_e'(reg_wdata_i[2:1]);
          if (reg_wdata_i[0] && !en[ch]) pc[ch] <= '0;
        end
        if (wr_cmp[ch]) cmp[ch] <= reg_wdata_i;
        if (wr_cnt[ch]) cnt[ch] <= reg_wdata_i;
      end
    end
  end

  assign irq_o  = flag & irq_en;
  assign busy_o = |en;

endmodule

// File: tb/tb_apb_timer_mc_core.sv
// Directed bench for apb_timer_mc_core: a vector table for the ch0 prescaled
// continuous / W1C scenario, plus hand sequences for one-shot, events, freeze and wrap.
module tb_apb_timer_mc_core;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PRESC_W = 8;
  localparam int ADDR_W  = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              stoptimer_i = 1'b0;
  logic [NUM_CH-1:0] event_i = '0;
  logic              reg_req_i = 1'b0;
  logic              reg_we_i = 1'b0;
  logic [ADDR_W-1:0] reg_addr_i = '0;
  logic [CNT_W-1:0]  reg_wdata_i = '0;
  logic [CNT_W-1:0]  reg_rdata_o;
  logic              reg_rvalid_o;
  logic [NUM_CH-1:0] irq_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] smp_irq;
  logic              smp_busy;
  logic [CNT_W-1:0]  rdat;

  apb_timer_mc_core #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .stoptimer_i (stoptimer_i),
    .event_i     (event_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_rvalid_o(reg_rvalid_o),
    .irq_o       (irq_o),
    .busy_o      (busy_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int                gap;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  data;
    logic [CNT_W-1:0]  exp;
    logic [NUM_CH-1:0] exp_irq;
    logic              exp_busy;
    string             name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] d);
    reg_req_i   = 1'b1;
    reg_we_i    = 1'b1;
    reg_addr_i  = a;
    reg_wdata_i = d;
    @(negedge HCLK);
    reg_req_i = 1'b0;
    reg_we_i  = 1'b0;
  endtask

  // Samples irq/busy as seen in the request cycle, then returns the read data.
  task automatic rd(input logic [ADDR_W-1:0] a, output logic [CNT_W-1:0] d);
    smp_irq    = irq_o;
    smp_busy   = busy_o;
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = a;
    @(negedge HCLK);
    check("rvalid", {63'd0, reg_rvalid_o}, 64'd1);
    d = reg_rdata_o;
    reg_req_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] exp);
    logic [CNT_W-1:0] d;
    rd(a, d);
    check(name, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic ev_pulse(input int w);
    event_i[2] = 1'b1;
    repeat (w) @(negedge HCLK);
    event_i[2] = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic add_wr(input int gap, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] d);
    vec_t v;
    v.gap = gap; v.we = 1'b1; v.addr = a; v.data = d;
    v.exp = '0; v.exp_irq = '0; v.exp_busy = 1'b0; v.name = "wr";
    vecs.push_back(v);
  endtask

  task automatic add_rd(input int gap, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] exp,
                        input logic [NUM_CH-1:0] irq, input logic busy, input string name);
    vec_t v;
    v.gap = gap; v.we = 1'b0; v.addr = a; v.data = '0;
    v.exp = exp; v.exp_irq = irq; v.exp_busy = busy; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ch0: CMP=4, presc=3, continuous, irq_en. E<n> = n-th enabled cycle after the CFG write.
    add_rd( 0, 4'd0, 32'h0,   4'h0, 1'b0, "reset_cfg0");
    add_rd( 0, 4'd3, 32'h0,   4'h0, 1'b0, "reset_sts0");
    add_wr( 0, 4'd1, 32'd4);
    add_wr( 0, 4'd0, 32'h30B);
    add_rd( 0, 4'd0, 32'h30B, 4'h0, 1'b1, "cfg0_readback");   // E1
    add_rd( 0, 4'd2, 32'd0,   4'h0, 1'b1, "cnt0_start");      // E2
    add_rd( 2, 4'd2, 32'd1,   4'h0, 1'b1, "cnt0_tick1");      // E5
    add_rd(11, 4'd2, 32'd4,   4'h0, 1'b1, "cnt0_tick4");      // E17
    add_rd( 2, 4'd3, 32'h2,   4'h0, 1'b1, "sts0_before");     // E20
    add_rd( 0, 4'd3, 32'h3,   4'h1, 1'b1, "sts0_match");      // E21
    add_rd( 0, 4'd2, 32'd0,   4'h1, 1'b1, "cnt0_reload");     // E22
    add_wr( 0, 4'd3, 32'h1);                                  // E23
    add_rd( 0, 4'd3, 32'h2,   4'h0, 1'b1, "sts0_w1c");        // E24
    add_wr(15, 4'd3, 32'h1);                                  // E40, match cycle
    add_rd( 0, 4'd3, 32'h3,   4'h1, 1'b1, "sts0_w1c_vs_set"); // E41
    add_wr( 0, 4'd3, 32'h1);                                  // E42
    add_rd( 0, 4'd3, 32'h2,   4'h0, 1'b1, "sts0_w1c_again");  // E43

    idle(3);
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      idle(vecs[i].gap);
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, rdat);
        check(vecs[i].name, {32'd0, rdat}, {32'd0, vecs[i].exp});
        check({vecs[i].name, "_irq"}, {60'd0, smp_irq}, {60'd0, vecs[i].exp_irq});
        check({vecs[i].name, "_busy"}, {63'd0, smp_busy}, {63'd0, vecs[i].exp_busy});
      end
    end

    // ch1 one-shot, CMP=2, presc=0; ch0 disabled so busy tracks ch1 alone.
    wr(4'd0, 32'h0);
    wr(4'd5, 32'd2);
    wr(4'd4, 32'h1);
    idle(2);
    rd_chk("os_sts_e3", 4'd7, 32'h2);
    check("os_busy_e3", {63'd0, smp_busy}, 64'd1);
    rd_chk("os_sts_e4", 4'd7, 32'h1);
    check("os_busy_e4", {63'd0, smp_busy}, 64'd0);
    check("os_irq_e4", {60'd0, smp_irq}, 64'd0);
    rd_chk("os_cnt_a", 4'd6, 32'd0);
    idle(2);
    rd_chk("os_cnt_b", 4'd6, 32'd0);

    // ch2 event count, CMP=3: two pulses, a 5-wide level (one edge), then a 4th edge.
    wr(4'd9, 32'd3);
    wr(4'd8, 32'h5);
    ev_pulse(1);
    ev_pulse(1);
    rd_chk("ev_cnt_2", 4'd10, 32'd2);
    ev_pulse(5);
    rd_chk("ev_cnt_level", 4'd10, 32'd3);
    rd_chk("ev_sts_pre", 4'd11, 32'h2);
    ev_pulse(1);
    rd_chk("ev_sts_match", 4'd11, 32'h3);
    rd_chk("ev_cnt_reload", 4'd10, 32'd0);

    // ch0 presc=0 continuous, frozen for 10 cycles; ch2 edge during freeze is lost.
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd1000);
    wr(4'd0, 32'h3);
    idle(4);
    stoptimer_i = 1'b1;
    rd_chk("stop_cnt_a", 4'd2, 32'd4);
    ev_pulse(1);
    idle(6);
    rd_chk("stop_cnt_b", 4'd2, 32'd4);
    stoptimer_i = 1'b0;
    rd_chk("resume_cnt_a", 4'd2, 32'd4);
    rd_chk("resume_cnt_b", 4'd2, 32'd5);
    rd_chk("stop_ev_lost", 4'd10, 32'd0);

    // ch3 wrap past all-ones without a flag, then match at 5; CNT write beats tick.
    wr(4'd13, 32'd5);
    wr(4'd14, 32'hFFFF_FFFE);
    wr(4'd12, 32'h3);
    idle(1);
    rd_chk("wrap_top", 4'd14, 32'hFFFF_FFFF);
    rd_chk("wrap_noflag", 4'd15, 32'h2);
    rd_chk("wrap_cnt1", 4'd14, 32'd1);
    idle(3);
    rd_chk("wrap_sts_pre", 4'd15, 32'h2);
    rd_chk("wrap_sts_match", 4'd15, 32'h3);
    wr(4'd14, 32'd100);
    rd_chk("cnt_wr_wins", 4'd14, 32'd100);
    rd_chk("cnt_after_wr", 4'd14, 32'd101);
    idle(1);
    check("rvalid_pulse", {63'd0, reg_rvalid_o}, 64'd0);

    // Reserved mode 11 leaves mode unchanged.
    wr(4'd8, 32'h7);
    rd_chk("cfg2_rsvd_mode", 4'd8, 32'h5);

    // Reset asserted in a read request cycle: no rvalid, everything cleared.
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = 4'd2;
    HRESETn    = 1'b0;
    @(negedge HCLK);
    check("rst_rvalid", {63'd0, reg_rvalid_o}, 64'd0);
    check("rst_rdata", {32'd0, reg_rdata_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_irq", {60'd0, irq_o}, 64'd0);
    reg_req_i = 1'b0;
    HRESETn   = 1'b1;
    rd_chk("rst_cnt0", 4'd2, 32'd0);
    rd_chk("rst_sts2", 4'd11, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
